// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds pixel coordinates from the active-low
// sync pair and tracks lock against the configured line and frame totals.
module vga_sync_decoder #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_h_sync,
  input  logic       i_v_sync,
  output logic [9:0] o_coord_x,
  output logic [9:0] o_coord_y,
  output logic       o_visible,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_error
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;

  localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  X_SYNC    = 10'(H_SYNC_START);
  localparam logic [9:0]  X_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_SYNC    = 10'(V_SYNC_START);
  localparam logic [9:0]  Y_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]  LC_TOTAL  = 10'(V_TOTAL);
  localparam logic [9:0]  LC_MAX    = 10'h3FF;
  localparam logic [10:0] LP_GOOD   = 11'(H_TOTAL - 1);
  localparam logic [10:0] LP_MAX    = 11'(2 * H_TOTAL);
  localparam logic [2:0]  GOOD_LOCK = 3'(LOCK_FRAMES);

  logic        h_q, v_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] lp_q, lp_d;
  logic [9:0]  lc_q, lc_d;
  logic        h_seen_q, h_seen_d;
  state_e      state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic        bad_q, bad_d;
  logic        locked_q, locked_d;
  logic        visible_q, visible_d;
  logic        frame_start_q, frame_start_d;
  logic        error_q, error_d;
  logic        hs_edge, vs_edge, x_wrap, hperr, vperr, timeout;

  always_comb begin
    hs_edge  = h_q & ~i_h_sync;
    vs_edge  = v_q & ~i_v_sync;
    x_wrap   = !hs_edge && (x_q == X_LAST);

    x_d = x_q + 10'd1;
    if (hs_edge)     x_d = X_SYNC;
    else if (x_wrap) x_d = '0;

    y_d = y_q;
    if (vs_edge)     y_d = Y_SYNC;
    else if (x_wrap) y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;

    lp_d = lp_q;
    if (hs_edge)             lp_d = '0;
    else if (lp_q != LP_MAX) lp_d = lp_q + 11'd1;

    timeout = !hs_edge && (lp_q == LP_MAX);
    hperr   = hs_edge && h_seen_q && (lp_q != LP_GOOD);

    h_seen_d = h_seen_q;
    if (hs_edge)      h_seen_d = 1'b1;
    else if (timeout) h_seen_d = 1'b0;

    // Line count is judged on its pre-clear value when both edges coincide.
    vperr = vs_edge && (lc_q != LC_TOTAL);
    lc_d  = lc_q;
    if (vs_edge)                      lc_d = '0;
    else if (hs_edge && lc_q != LC_MAX) lc_d = lc_q + 10'd1;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    error_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d = VERIFY;
          good_d  = '0;
          bad_d   = 1'b0;
        end
      end
      VERIFY: begin
        if (timeout) begin
          state_d = SEARCH;
        end else if (vs_edge) begin
          if (bad_q || hperr || vperr) begin
            good_d = '0;
            bad_d  = 1'b0;
          end else begin
            good_d = good_q + 3'd1;
            if (good_d == GOOD_LOCK) state_d = LOCKED;
          end
        end else if (hperr) begin
          bad_d = 1'b1;
        end
      end
      LOCKED: begin
        if (hperr || vperr || timeout) begin
          state_d = SEARCH;
          error_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d      = (state_d == LOCKED);
    visible_d     = locked_d && (x_d < X_VIS) && (y_d < Y_VIS);
    frame_start_d = locked_d && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEARCH;
      good_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q           <= 1'b1;
      v_q           <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      lp_q          <= '0;
      lc_q          <= '0;
      h_seen_q      <= 1'b0;
      locked_q      <= 1'b0;
      visible_q     <= 1'b0;
      frame_start_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      h_q           <= i_h_sync;
      v_q           <= i_v_sync;
      x_q           <= x_d;
      y_q           <= y_d;
      lp_q          <= lp_d;
      lc_q          <= lc_d;
      h_seen_q      <= h_seen_d;
      locked_q      <= locked_d;
      visible_q     <= visible_d;
      frame_start_q <= frame_start_d;
      error_q       <= error_d;
    end
  end

  assign o_coord_x     = x_q;
  assign o_coord_y     = y_q;
  assign o_visible     = visible_q;
  assign o_frame_start = frame_start_q;
  assign o_locked      = locked_q;
  assign o_error       = error_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (24x15 clocks/lines) so whole
// frames fit a short run; every cycle is also compared with a timestamp-based model.
module tb_vga_sync_decoder;
  localparam int HV = 16, HSS = 18, HT = 24, HSW = 3;
  localparam int VV = 10, VSS = 12, VT = 15, VSW = 2, LF = 2;
  localparam int FRAME = HT * VT;

  logic       clk, rst_n, h_sync, v_sync;
  logic [9:0] cx, cy;
  logic       vis, fs, lock, err;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_TOTAL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_h_sync(h_sync), .i_v_sync(v_sync),
    .o_coord_x(cx), .o_coord_y(cy), .o_visible(vis), .o_frame_start(fs),
    .o_locked(lock), .o_error(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, errors = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: periods measured as differences of edge timestamps.
  int  m_x, m_y, m_cyc, m_last_hs, m_lines, m_mode, m_good;
  bit  m_hseen, m_bad, m_hprev, m_vprev;
  logic [23:0] m_out;

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_cyc = 0; m_last_hs = -1; m_lines = 0;
    m_mode = 0; m_good = 0; m_hseen = 0; m_bad = 0;
    m_hprev = 1; m_vprev = 1; m_out = '0;
  endfunction

  function automatic void model_step(input logic h, input logic v);
    bit hs, vs, hperr, vperr, tmo, wrap, lk, e;
    int since;
    hs    = m_hprev && !h;
    vs    = m_vprev && !v;
    since = m_cyc - m_last_hs;
    hperr = hs && m_hseen && (since != HT);
    tmo   = !hs && (since > 2 * HT);
    vperr = vs && (m_lines != VT);
    e = 0;
    if (m_mode == 0) begin
      if (vs) begin m_mode = 1; m_good = 0; m_bad = 0; end
    end else if (m_mode == 1) begin
      if (tmo) m_mode = 0;
      else if (vs) begin
        if (m_bad || hperr || vperr) begin m_good = 0; m_bad = 0; end
        else begin m_good++; if (m_good == LF) m_mode = 2; end
      end else if (hperr) m_bad = 1;
    end else if (hperr || vperr || tmo) begin
      m_mode = 0; e = 1;
    end
    wrap = !hs && (m_x == HT - 1);
    m_x  = hs ? HSS : (wrap ? 0 : m_x + 1);
    m_y  = vs ? VSS : (wrap ? (m_y + 1) % VT : m_y);
    m_lines = vs ? 0 : (hs ? ((m_lines + 1 > 1023) ? 1023 : m_lines + 1) : m_lines);
    if (hs) begin m_hseen = 1; m_last_hs = m_cyc; end
    else if (tmo) m_hseen = 0;
    m_hprev = h; m_vprev = v; m_cyc++;
    lk = (m_mode == 2);
    m_out = {10'(m_x), 10'(m_y), lk && m_x < HV && m_y < VV, lk && m_x == 0 && m_y == 0, lk, e};
  endfunction

  task automatic tick(input logic h, input logic v);
    h_sync = h;
    v_sync = v;
    @(posedge clk);
    model_step(h, v);
    cyc++;
    #1;
    check("model", {8'd0, cx, cy, vis, fs, lock, err}, {8'd0, m_out});
  endtask

  // Sync generator with hooks for line/frame length changes and sync faults.
  int gx = 0, gy = 0, g_htot = HT, g_vtot = VT, g_force = 0, g_glitch = -1, px, py;
  logic g_hprev = 1'b1, g_vprev = 1'b1;
  bit g_hs_evt, g_vs_evt;

  task automatic gen_tick();
    logic h, v;
    h = !(gx >= HSS && gx < HSS + HSW);
    v = !(gy >= VSS && gy < VSS + VSW);
    if (g_force > 0) h = 1'b1;
    if (gx == g_glitch) h = 1'b0;
    g_hs_evt = g_hprev && !h;
    g_vs_evt = g_vprev && !v;
    g_hprev = h; g_vprev = v; px = gx; py = gy;
    tick(h, v);
    gx++;
    if (gx >= g_htot) begin
      gx = 0; g_htot = HT; g_glitch = -1;
      if (g_force > 0) g_force--;
      gy++;
      if (gy >= g_vtot) begin gy = 0; g_vtot = VT; end
    end
  endtask

  // kind: 0 = generator pixel (tx,ty) applied, 1 = vsync edge, 2 = hsync edge, 3 = frame_start seen
  task automatic gen_until(input int kind, input int tx, input int ty, input int limit, output bit found);
    found = 0;
    for (int i = 0; i < limit; i++) begin
      gen_tick();
      if ((kind == 0 && px == tx && py == ty) || (kind == 1 && g_vs_evt) ||
          (kind == 2 && g_hs_evt) || (kind == 3 && fs)) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", {8'd0, cx, cy, vis, fs, lock, err}, 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    g_hprev = 1'b1;
    g_vprev = 1'b1;
  endtask

  task automatic expect_relock(input string name);
    bit f;
    for (int k = 1; k <= LF + 1; k++) begin
      gen_until(1, 0, 0, 3 * FRAME, f);
      check({name, "_vs_found"}, 32'(f), 32'd1);
      check(name, 32'(lock), 32'(k == LF + 1));
    end
  endtask

  typedef struct {
    int   x;
    int   y;
    logic vis;
    logic fs;
  } vis_vec_t;

  vis_vec_t vtab[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    int c0, mism, e;

    vtab[0] = '{0,      0,      1'b1, 1'b1};
    vtab[1] = '{HV - 1, 0,      1'b1, 1'b0};
    vtab[2] = '{0,      VV - 1, 1'b1, 1'b0};
    vtab[3] = '{HV - 1, VV - 1, 1'b1, 1'b0};
    vtab[4] = '{HV,     VV - 1, 1'b0, 1'b0};
    vtab[5] = '{0,      VV,     1'b0, 1'b0};
    vtab[6] = '{HT - 1, VT - 1, 1'b0, 1'b0};
    vtab[7] = '{0,      0,      1'b1, 1'b1};

    rst_n = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
    model_reset();
    #2;
    do_reset(3);
    check("reset_x", 32'(cx), 32'd0);
    check("reset_locked", 32'(lock), 32'd0);

    // Ideal stream from (0,0): lock on the third vsync edge.
    expect_relock("lock_ideal");

    mism = 0;
    for (int i = 0; i < FRAME; i++) begin
      gen_tick();
      if (cx != 10'(px) || cy != 10'(py)) mism++;
    end
    check("coord_delay_mismatches", 32'(mism), 32'd0);

    gen_until(3, 0, 0, 2 * FRAME, f);
    check("fs_first_found", 32'(f), 32'd1);
    c0 = cyc;
    gen_until(3, 0, 0, 2 * FRAME, f);
    check("fs_second_found", 32'(f), 32'd1);
    check("fs_interval", 32'(cyc - c0), 32'(FRAME));

    for (int i = 0; i < 8; i++) begin
      gen_until(0, vtab[i].x, vtab[i].y, 2 * FRAME, f);
      check("vis_reach", 32'(f), 32'd1);
      check("vis_coord", {12'd0, cx, cy}, {12'd0, 10'(vtab[i].x), 10'(vtab[i].y)});
      check("vis_flag", 32'(vis), 32'(vtab[i].vis));
      check("vis_frame_start", 32'(fs), 32'(vtab[i].fs));
    end

    // One short line while locked.
    gen_until(0, HT - 1, 1, 2 * FRAME, f);
    check("pre_short_line_lock", 32'(lock), 32'd1);
    g_htot = HT - 1;
    gen_until(2, 0, 0, 2 * HT, f);
    check("short_line_first_hs_err", 32'(err), 32'd0);
    gen_until(2, 0, 0, 2 * HT, f);
    check("short_line_err", 32'(err), 32'd1);
    check("short_line_lock", 32'(lock), 32'd0);
    gen_tick();
    check("short_line_err_one_cycle", 32'(err), 32'd0);
    expect_relock("relock_after_short_line");

    // One short frame while locked.
    gen_until(0, HT - 1, VT - 1, 2 * FRAME, f);
    g_vtot = VT - 1;
    gen_until(1, 0, 0, 2 * FRAME, f);
    check("short_frame_prev_vs_err", 32'(err), 32'd0);
    check("short_frame_prev_vs_lock", 32'(lock), 32'd1);
    gen_until(1, 0, 0, 2 * FRAME, f);
    check("short_frame_err", 32'(err), 32'd1);
    check("short_frame_lock", 32'(lock), 32'd0);
    expect_relock("relock_after_short_frame");

    // Asynchronous reset mid-line while locked.
    gen_until(0, 7, 5, 2 * FRAME, f);
    check("pre_reset_lock", 32'(lock), 32'd1);
    do_reset(2);
    expect_relock("relock_after_reset");

    // Loss of hsync while locked, then again while unlocked.
    gen_until(0, HT - 1, 0, 2 * FRAME, f);
    check("pre_hloss_lock", 32'(lock), 32'd1);
    g_force = 3;
    e = 0;
    for (int i = 0; i < 3 * HT; i++) begin gen_tick(); if (err) e++; end
    check("hloss_err_pulses", 32'(e), 32'd1);
    check("hloss_lock", 32'(lock), 32'd0);
    g_force = 3;
    e = 0;
    for (int i = 0; i < 3 * HT; i++) begin gen_tick(); if (err) e++; end
    check("hloss_unlocked_err_pulses", 32'(e), 32'd0);
    check("hloss_unlocked_lock", 32'(lock), 32'd0);

    // Randomized disturbances, checked cycle by cycle against the model.
    for (int ln = 0; ln < 1200; ln++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)       g_htot = HT - 1;
      else if (r < 4)  g_htot = HT + 1;
      else if (r < 6)  g_force = $urandom_range(1, 3);
      else if (r < 8)  g_glitch = $urandom_range(0, HT - 1);
      else if (r < 10) g_vtot = ($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1;
      else if (r < 11) do_reset($urandom_range(1, 3));
      for (int i = 0; i < HT + 2; i++) begin
        gen_tick();
        if (gx == 0) break;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
